// File: rtl/mix_seq_pkg.sv
// rtl/mix_seq_pkg.sv - shared constants and FSM state type for the mix sequencer
package mix_seq_pkg;

    localparam int NUM_VOICES = 12;
    localparam int SAMPLE_W   = 8;
    localparam int ACC_W      = 12;
    localparam int CNT_W      = $clog2(NUM_VOICES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DIVIDE,
        S_WAIT,
        S_OUTPUT
    } state_t;

endpackage

// File: rtl/voice_accumulator.sv
// rtl/voice_accumulator.sv - serial voice scanner: latched key mask, voice mux, sum and count
module voice_accumulator #(
    parameter int NUM_VOICES = mix_seq_pkg::NUM_VOICES,
    parameter int SAMPLE_W   = mix_seq_pkg::SAMPLE_W,
    parameter int ACC_W      = mix_seq_pkg::ACC_W,
    localparam int CNT_W     = $clog2(NUM_VOICES + 1),
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           step,
    input  logic [NUM_VOICES-1:0]          key_en,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    output logic [ACC_W-1:0]               acc,
    output logic [ACC_W-1:0]               acc_next,
    output logic [CNT_W-1:0]               cnt,
    output logic [CNT_W-1:0]               cnt_next,
    output logic                           last
);

    logic [NUM_VOICES-1:0] key_q;
    logic [IDX_W-1:0]      idx;
    logic [SAMPLE_W-1:0]   sel;
    logic                  hit;

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (int'(idx) == i) begin
                sel = voice_samples[i*SAMPLE_W +: SAMPLE_W];
                hit = key_q[i];
            end
        end
    end

    // Sum/count including the voice under the index, so the FSM can decide on the last scan cycle
    assign acc_next = hit ? acc + {{(ACC_W-SAMPLE_W){1'b0}}, sel} : acc;
    assign cnt_next = cnt + {{(CNT_W-1){1'b0}}, hit};
    assign last     = (idx == IDX_W'(NUM_VOICES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q <= '0;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (clear) begin
            key_q <= key_en;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt_next;
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mix_sequencer.sv
// rtl/mix_sequencer.sv - per-tick voice mix and normalise sequencer; MIX_SEQ_SINGLE_BYPASS_EN skips the divider for one voice
module mix_sequencer #(
    parameter int NUM_VOICES  = mix_seq_pkg::NUM_VOICES,
    parameter int SAMPLE_W    = mix_seq_pkg::SAMPLE_W,
    parameter int ACC_W       = mix_seq_pkg::ACC_W,
    parameter int DIV_TIMEOUT = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_now,
    input  logic [NUM_VOICES-1:0]          key_en,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    output logic                           div_start,
    output logic [ACC_W-1:0]               div_dividend,
    output logic [ACC_W-1:0]               div_divisor,
    input  logic [SAMPLE_W-1:0]            div_quo,
    input  logic                           div_done,
    output logic [SAMPLE_W-1:0]            final_sample,
    output logic                           pwm_start,
    output logic                           busy,
    output logic                           overrun,
    output logic                           div_timeout
);

    import mix_seq_pkg::*;

    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam int TMR_W = $clog2(DIV_TIMEOUT + 1);

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               last;

    voice_accumulator #(
        .NUM_VOICES (NUM_VOICES),
        .SAMPLE_W   (SAMPLE_W),
        .ACC_W      (ACC_W)
    ) u_acc (
        .clk           (clk),
        .reset         (reset),
        .clear         ((state == S_IDLE) && sample_now),
        .step          (state == S_SCAN),
        .key_en        (key_en),
        .voice_samples (voice_samples),
        .acc           (acc),
        .acc_next      (acc_next),
        .cnt           (cnt),
        .cnt_next      (cnt_next),
        .last          (last)
    );

    // acc/cnt are frozen after the scan until the next accepted tick, so they hold across the divide
    assign div_dividend = acc;
    assign div_divisor  = {{(ACC_W-CNT_W){1'b0}}, cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            div_start    <= 1'b0;
            final_sample <= '0;
            pwm_start    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            div_timeout  <= 1'b0;
        end else begin
            div_start <= 1'b0;
            pwm_start <= 1'b0;
            if (sample_now && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (sample_now) begin
                        state <= S_SCAN;
                        busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (last) begin
                        if (cnt_next == '0) begin
                            final_sample <= '0;
                            pwm_start    <= 1'b1;
                            state        <= S_OUTPUT;
                        end
`ifdef MIX_SEQ_SINGLE_BYPASS_EN
                        else if (cnt_next == CNT_W'(1)) begin
                            final_sample <= acc_next[SAMPLE_W-1:0];
                            pwm_start    <= 1'b1;
                            state        <= S_OUTPUT;
                        end
`endif
                        else begin
                            div_start <= 1'b1;
                            state     <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        final_sample <= div_quo;
                        pwm_start    <= 1'b1;
                        state        <= S_OUTPUT;
                    end else if (timer == TMR_W'(DIV_TIMEOUT - 1)) begin
                        div_timeout <= 1'b1;
                        pwm_start   <= 1'b1;
                        state       <= S_OUTPUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_sequencer.sv
// tb/tb_mix_sequencer.sv - self-checking bench for mix_sequencer with a latency divider model
module tb_mix_sequencer;

    localparam int NV = 12;
    localparam int SW = 8;
    localparam int AW = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic           sample_now;
    logic [NV-1:0]  key_en;
    logic [NV*SW-1:0] voice_samples;
    logic           div_start;
    logic [AW-1:0]  div_dividend;
    logic [AW-1:0]  div_divisor;
    logic [SW-1:0]  div_quo;
    logic           div_done;
    logic [SW-1:0]  final_sample;
    logic           pwm_start;
    logic           busy;
    logic           overrun;
    logic           div_timeout;

    mix_sequencer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ACC_W(AW), .DIV_TIMEOUT(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_now    (sample_now),
        .key_en        (key_en),
        .voice_samples (voice_samples),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quo       (div_quo),
        .div_done      (div_done),
        .final_sample  (final_sample),
        .pwm_start     (pwm_start),
        .busy          (busy),
        .overrun       (overrun),
        .div_timeout   (div_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred where none was expected", name);
    endtask

    typedef struct {
        logic [SW-1:0] fin;
        logic          use_div;
        logic          tmo;
        logic [AW-1:0] dvd;
        logic [AW-1:0] dvs;
        int            tick;
    } exp_t;

    typedef struct {
        logic [NV-1:0]    key;
        logic [NV*SW-1:0] voices;
        logic [SW-1:0]    fin;
        logic [AW-1:0]    dvd;
        logic [AW-1:0]    dvs;
        logic             use_div;
    } vec_t;

    exp_t sb[$];
    exp_t got_e;
    vec_t vecs[5];

    bit   hang = 0;
    bit   pend = 0;
    int   dcnt = 0;
    int   done_cyc = -100;
    int   pwm_count = 0;
    int   dstart_count = 0;
    logic [AW-1:0] mdvd, mdvs;

    // Divider model: 14-cycle latency from div_start to div_done, or never returns when hang is set
    initial begin
        div_done = 1'b0;
        div_quo  = '0;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (div_start) begin
                dstart_count++;
                if (sb.size() == 0 || !sb[0].use_div) begin
                    flag("div_start_unexpected");
                end else begin
                    check("div_start_cycle", cyc, sb[0].tick + 13);
                    check("div_dividend", div_dividend, sb[0].dvd);
                    check("div_divisor", div_divisor, sb[0].dvs);
                end
                mdvd = div_dividend;
                mdvs = div_divisor;
                if (hang) begin
                    div_quo = 8'h5A;
                end else begin
                    pend = 1;
                    dcnt = 14;
                end
            end else if (pend) begin
                dcnt--;
                if (dcnt == 0) begin
                    div_done = 1'b1;
                    div_quo  = (mdvs == 0) ? 8'hFF : SW'(mdvd / mdvs);
                    pend     = 0;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && pwm_start) begin
                pwm_count++;
                if (sb.size() == 0) begin
                    flag("pwm_start_unexpected");
                end else begin
                    got_e = sb.pop_front();
                    check("final_sample", final_sample, got_e.fin);
                    check("busy_in_output", busy, 1);
                    if (got_e.tmo) begin
                        check("timeout_pwm_cycle", cyc, got_e.tick + 46);
                        check("div_timeout_set", div_timeout, 1);
                    end else if (got_e.use_div) begin
                        check("pwm_after_done", cyc, done_cyc + 1);
                    end else begin
                        check("pwm_direct_cycle", cyc, got_e.tick + 13);
                    end
                end
            end
        end
    end

    task automatic tick(input logic [NV-1:0] k, input logic [NV*SW-1:0] v, output int t);
        @(posedge clk);
        #1;
        key_en        = k;
        voice_samples = v;
        sample_now    = 1'b1;
        t             = cyc;
        @(posedge clk);
        #1;
        sample_now = 1'b0;
        key_en     = ~k;
    endtask

    task automatic push(input logic [SW-1:0] fin, input logic use_div, input logic tmo,
                        input logic [AW-1:0] dvd, input logic [AW-1:0] dvs, input int t);
        exp_t e;
        e.fin = fin; e.use_div = use_div; e.tmo = tmo; e.dvd = dvd; e.dvs = dvs; e.tick = t;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding after 200 cycles", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_dividend"}, div_dividend, 0);
        check({tag, "_divisor"}, div_divisor, 0);
        check({tag, "_final"}, final_sample, 0);
        check({tag, "_pwm"}, pwm_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, div_timeout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t, p0, d0;
        logic [NV*SW-1:0] v;

        reset = 1'b1; sample_now = 1'b0; key_en = '0; voice_samples = '0;

        for (int i = 0; i < NV; i++) v[i*SW +: SW] = 8'hAA;
        vecs[0] = '{key: 12'h000, voices: v, fin: 8'd0, dvd: 12'd0, dvs: 12'd0, use_div: 1'b0};
        v = '0; v[0*SW +: SW] = 8'd200; v[1*SW +: SW] = 8'd50; v[2*SW +: SW] = 8'd100;
        vecs[1] = '{key: 12'h005, voices: v, fin: 8'd150, dvd: 12'd300, dvs: 12'd2, use_div: 1'b1};
        v = '1;
        vecs[2] = '{key: 12'hFFF, voices: v, fin: 8'd255, dvd: 12'd3060, dvs: 12'd12, use_div: 1'b1};
        v = '0; v[4*SW +: SW] = 8'd77; v[3*SW +: SW] = 8'd9; v[5*SW +: SW] = 8'd11;
        vecs[3] = '{key: 12'h010, voices: v, fin: 8'd77, dvd: 12'd77, dvs: 12'd1, use_div: 1'b1};
`ifdef MIX_SEQ_SINGLE_BYPASS_EN
        vecs[3].use_div = 1'b0;
`endif
        v = '0; v[0*SW +: SW] = 8'd10; v[1*SW +: SW] = 8'd20; v[2*SW +: SW] = 8'd99;
        v[5*SW +: SW] = 8'd30; v[7*SW +: SW] = 8'd40; v[11*SW +: SW] = 8'd123;
        vecs[4] = '{key: 12'h0A3, voices: v, fin: 8'd25, dvd: 12'd100, dvs: 12'd4, use_div: 1'b1};

        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1; reset = 1'b0;

        p0 = pwm_count;
        repeat (100) @(posedge clk);
        check("idle_no_pwm", pwm_count, p0);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            d0 = dstart_count;
            tick(vecs[i].key, vecs[i].voices, t);
            push(vecs[i].fin, vecs[i].use_div, 1'b0, vecs[i].dvd, vecs[i].dvs, t);
            drain();
            check("div_start_count", dstart_count - d0, vecs[i].use_div ? 1 : 0);
            check("busy_after_tick", busy, 0);
        end

        // Divider never answers: previous final_sample (25) must be re-issued
        check("timeout_clear_before", div_timeout, 0);
        hang = 1;
        tick(vecs[1].key, vecs[1].voices, t);
        push(8'd25, 1'b1, 1'b1, 12'd300, 12'd2, t);
        drain();
        hang = 0;
        check("timeout_sticky", div_timeout, 1);

        check("overrun_clear_before", overrun, 0);
        p0 = pwm_count;
        tick(vecs[1].key, vecs[1].voices, t);
        push(8'd150, 1'b1, 1'b0, 12'd300, 12'd2, t);
        repeat (4) @(posedge clk);
        #1; sample_now = 1'b1;
        @(posedge clk); #1; sample_now = 1'b0;
        drain();
        check("overrun_set", overrun, 1);
        check("overrun_single_pwm", pwm_count - p0, 1);
        tick(vecs[0].key, vecs[0].voices, t);
        push(8'd0, 1'b0, 1'b0, 12'd0, 12'd0, t);
        drain();
        check("overrun_sticky", overrun, 1);

        // Reset mid-scan aborts the tick: no pwm_start, flags and outputs cleared
        p0 = pwm_count;
        tick(vecs[1].key, vecs[1].voices, t);
        repeat (7) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("abort");
        @(posedge clk); #1; reset = 1'b0;
        repeat (40) @(posedge clk);
        check("abort_no_pwm", pwm_count, p0);
        check("abort_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_sequencer.md
# mix_sequencer

Sample-rate controller that time-multiplexes the voice-mixing and normalisation path. On each sample tick it scans the 12 waveshaper outputs serially and accumulates the held-key voices. It then runs the shared sequential divider to normalise the sum by the voice count, and hands the result to the PWM stage with a start pulse. It sits between the sample-rate clock divider and waveshapers upstream, and the sequential divider and pwm blocks downstream, replacing the combinational signal mixer.

## Interface
Parameters:
- NUM_VOICES, 12, number of voices scanned per tick
- SAMPLE_W, 8, width of each voice sample and of the final sample
- ACC_W, 12, accumulator/dividend width; must hold NUM_VOICES*(2^SAMPLE_W-1)
- DIV_TIMEOUT, 32, max cycles waited for div_done before abort

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  reset, asynchronous, active-high
- sample_now  in  1  one-cycle sample tick
- key_en  in  NUM_VOICES  per-voice key held (pb[11:0])
- voice_samples  in  NUM_VOICES*SAMPLE_W  flattened; voice i at [SAMPLE_W*i +: SAMPLE_W]
- div_start  out  1  one-cycle start to sequential divider
- div_dividend  out  ACC_W  accumulated sum, stable from div_start until div_done
- div_divisor  out  ACC_W  enabled-voice count, zero-extended, same stability rule
- div_quo  in  SAMPLE_W  divider quotient
- div_done  in  1  divider completion pulse
- final_sample  out  SAMPLE_W  normalised sample to pwm
- pwm_start  out  1  one-cycle pulse, final_sample valid
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky: tick arrived while busy
- div_timeout  out  1  sticky: divider failed to finish

## Operation
- States: IDLE, SCAN, DIVIDE, WAIT, OUTPUT.
- IDLE: on sample_now, latch key_en into key_q, clear accumulator and count, set idx=0, go SCAN.
- SCAN: one voice per cycle. If key_q[idx], acc += voice_samples[idx] and cnt += 1. After idx=NUM_VOICES-1:
  - cnt==0: result=0, go to OUTPUT.
  - Otherwise go to DIVIDE.
- DIVIDE: assert div_start for one cycle, then go to WAIT. Clear the timer.
- WAIT: on div_done, capture div_quo and go to OUTPUT. If the timer reaches DIV_TIMEOUT, set div_timeout, keep the previous final_sample, and go to OUTPUT.
- OUTPUT: update final_sample, assert pwm_start, return to IDLE.
- sample_now outside IDLE: dropped, overrun set. It is not queued.
- div_done outside WAIT is ignored.
- Arithmetic is unsigned. The accumulator never overflows at the default parameters (max 3060). The count is 4 bits.
- Reset values: every output is 0, state IDLE, acc/cnt/idx/timer 0, sticky flags cleared. Assertion mid-operation aborts immediately. No pwm_start is issued for the aborted tick.
- Sticky flags clear only on reset.

## Timing
- sample_now at cycle T → voice i is sampled at T+1+i. SCAN occupies T+1..T+12.
- Zero keys: OUTPUT and pwm_start at T+13, final_sample=0 from T+13.
- Non-zero keys: div_start at T+13. div_done seen at cycle D gives pwm_start at D+1, with final_sample updated the same cycle.
- busy is high from T+1 through the OUTPUT cycle inclusive.
- A sample_now coinciding with the OUTPUT cycle is an overrun. The next tick is accepted only when the FSM is in IDLE.
- Key changes after T do not affect the tick in progress. voice_samples are read live during SCAN.

## Configuration
- MIX_SEQ_SINGLE_BYPASS_EN defined: cnt==1 after SCAN skips the divider. SCAN → OUTPUT with final_sample=acc[SAMPLE_W-1:0], pwm_start at T+13, no div_start.
- Undefined: cnt==1 goes through DIVIDE/WAIT like any other non-zero count.

## Structure
- Package mix_seq_pkg holds:
  - the state enum type
  - NUM_VOICES, SAMPLE_W, ACC_W and CNT_W=$clog2(NUM_VOICES+1) constants
- Sub-module voice_accumulator holds acc, cnt and idx, with clear/step inputs and the voice mux. The FSM and timer stay in mix_sequencer.

## Test plan
- Reset then idle: all outputs 0, busy 0; no pwm_start for 100 cycles without a tick.
- key_en=0x000, tick at T: pwm_start at T+13, final_sample=0, div_start never asserted.
- key_en=0x005, voice0=200, voice2=100; divider model with 14-cycle latency: div_dividend=300, div_divisor=2, final_sample=150, pwm_start one cycle after div_done.
- key_en=0xFFF, all voices 255: dividend 3060, divisor 12, final_sample=255, no overflow.
- Second sample_now at T+5: overrun=1 and sticky, only one pwm_start. Reset at T+8: all outputs 0, overrun cleared.
- Divider model never returns div_done: div_timeout=1 after 32 WAIT cycles, pwm_start issued with previous final_sample. With MIX_SEQ_SINGLE_BYPASS_EN and key_en=0x010, voice4=77: final_sample=77 at T+13, no div_start.
